rf_scoreboard: RTL and testbench

- Issue-side hazard controller for the dual-issue register file read stage.
- Tracks in-flight writers per architectural register with a small counter.
- Grants issue to slot 0/slot 1 only when all enabled sources are ready; ready means no pending writer, or the last pending writer retires this cycle on a register-file write port (covered by the RF same-cycle bypass).
- Clears pending state on writeback and on pipeline flush.

---
 rtl/rf_scoreboard_pkg.sv | 12 +
 rtl/rf_scoreboard_entry.sv | 50 +++++
 rtl/rf_scoreboard.sv | 95 +++++++++
 tb/tb_rf_scoreboard.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and helpers for the register-file issue scoreboard.
package rf_scoreboard_pkg;
   localparam int NREG  = 32;
   localparam int CNT_W = 2;
   localparam int IDX_W = 5;
   localparam logic [IDX_W-1:0] REG_ZERO = 5'd0;

   // Sum of two single-bit strobes as a 0..2 count.
   function automatic logic [1:0] hit2(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction
endpackage

// File: rtl/rf_scoreboard_entry.sv
// Per-register pending-writer counter: nets issues against writebacks, clamps at 0.
module sb_entry #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic [1:0]       inc,
   input  logic [1:0]       dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ready_now,
   output logic             busy,
   output logic             underflow
);
   localparam int SW = CNT_W + 2;
   localparam logic [SW-1:0] MAX_W = SW'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    sum, diff;

   always_comb begin
      sum       = SW'(cnt_q) + SW'(inc);
      diff      = '0;
      cnt_d     = cnt_q;
      underflow = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (sum < SW'(dec)) begin
         cnt_d     = '0;
         underflow = 1'b1;
      end else begin
         diff  = sum - SW'(dec);
         cnt_d = (diff > MAX_W) ? MAX_W[CNT_W-1:0] : diff[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
         busy  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         busy  <= |cnt_d;
      end
   end

   // A writeback retiring the last pending writer this cycle counts as ready (RF bypass).
   assign ready_now = (SW'(cnt_q) <= SW'(dec));
   assign cnt       = cnt_q;
endmodule

// File: rtl/rf_scoreboard.sv
// Dual-issue RAW/saturation hazard scoreboard for the register-file read stage.
module rf_scoreboard
   import rf_scoreboard_pkg::*;
#(
   parameter int NREG_P  = NREG,
   parameter int CNT_W_P = CNT_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             stall_in,
   input  logic             iss0_valid,
   input  logic [IDX_W-1:0] iss0_rj,
   input  logic [IDX_W-1:0] iss0_rk,
   input  logic [IDX_W-1:0] iss0_rd,
   input  logic             iss0_use_rj,
   input  logic             iss0_use_rk,
   input  logic             iss0_we,
   input  logic             iss1_valid,
   input  logic [IDX_W-1:0] iss1_rj,
   input  logic [IDX_W-1:0] iss1_rk,
   input  logic [IDX_W-1:0] iss1_rd,
   input  logic             iss1_use_rj,
   input  logic             iss1_use_rk,
   input  logic             iss1_we,
   input  logic             wb0_en,
   input  logic [IDX_W-1:0] wb0_addr,
   input  logic             wb1_en,
   input  logic [IDX_W-1:0] wb1_addr,
   output logic             grant0,
   output logic             grant1,
   output logic [NREG_P-1:0] busy,
   output logic [31:0]      stall_cycles,
   output logic             underflow_err
);
   localparam int LIM = (1 << CNT_W_P) - 1;

   logic [NREG_P-1:0][CNT_W_P-1:0] cnt;
   logic [NREG_P-1:0][1:0]         dec;
   logic [NREG_P-1:1][1:0]         inc;
   logic [NREG_P-1:0]              ready;
   logic [NREG_P-1:0]              uf;
   int                             eff0, eff1;
   logic                           src0_ok, src1_ok, raw01;

   assign cnt[0]   = '0;
   assign ready[0] = 1'b1;
   assign busy[0]  = 1'b0;
   assign uf[0]    = 1'b0;

   for (genvar r = 0; r < NREG_P; r++) begin : g_dec
      assign dec[r] = hit2(wb0_en && (wb0_addr == IDX_W'(r)), wb1_en && (wb1_addr == IDX_W'(r)));
   end

   for (genvar r = 1; r < NREG_P; r++) begin : g_ent
      assign inc[r] = hit2(grant0 && iss0_we && (iss0_rd == IDX_W'(r)),
                           grant1 && iss1_we && (iss1_rd == IDX_W'(r)));
      sb_entry #(.CNT_W(CNT_W_P)) u_ent (
         .clk       (clk),
         .rstn      (rstn),
         .clr       (flush),
         .inc       (inc[r]),
         .dec       (dec[r]),
         .cnt       (cnt[r]),
         .ready_now (ready[r]),
         .busy      (busy[r]),
         .underflow (uf[r])
      );
   end

   always_comb begin
      eff0    = int'(cnt[iss0_rd]) - int'(dec[iss0_rd]) + 1;
      eff1    = int'(cnt[iss1_rd]) - int'(dec[iss1_rd]) + 1
              + ((iss0_we && (iss0_rd == iss1_rd)) ? 1 : 0);
      src0_ok = (!iss0_use_rj || ready[iss0_rj]) && (!iss0_use_rk || ready[iss0_rk]);
      src1_ok = (!iss1_use_rj || ready[iss1_rj]) && (!iss1_use_rk || ready[iss1_rk]);
      // Slot 1 cannot see slot 0's result in the same read stage.
      raw01   = iss0_we && (iss0_rd != REG_ZERO) &&
                ((iss1_use_rj && (iss1_rj == iss0_rd)) || (iss1_use_rk && (iss1_rk == iss0_rd)));
      grant0  = rstn && !flush && !stall_in && iss0_valid && src0_ok &&
                (!(iss0_we && (iss0_rd != REG_ZERO)) || (eff0 <= LIM));
      grant1  = grant0 && iss1_valid && src1_ok && !raw01 &&
                (!(iss1_we && (iss1_rd != REG_ZERO)) || (eff1 <= LIM));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cycles  <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (iss0_valid && !grant0) stall_cycles <= stall_cycles + 32'd1;
         if (|uf) underflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed + random bench for rf_scoreboard against an array-based reference model.
module tb_rf_scoreboard;
   logic        clk = 1'b0;
   logic        rstn, flush, stall_in;
   logic        iss0_valid, iss0_use_rj, iss0_use_rk, iss0_we;
   logic [4:0]  iss0_rj, iss0_rk, iss0_rd;
   logic        iss1_valid, iss1_use_rj, iss1_use_rk, iss1_we;
   logic [4:0]  iss1_rj, iss1_rk, iss1_rd;
   logic        wb0_en, wb1_en;
   logic [4:0]  wb0_addr, wb1_addr;
   logic        grant0, grant1, underflow_err;
   logic [31:0] busy, stall_cycles;

   int          errors = 0, checks = 0;
   int          mc[32];
   int unsigned mstall;
   bit          muf, mg0, mg1;
   logic        og0, og1;

   rf_scoreboard dut (
      .clk(clk), .rstn(rstn), .flush(flush), .stall_in(stall_in),
      .iss0_valid(iss0_valid), .iss0_rj(iss0_rj), .iss0_rk(iss0_rk), .iss0_rd(iss0_rd),
      .iss0_use_rj(iss0_use_rj), .iss0_use_rk(iss0_use_rk), .iss0_we(iss0_we),
      .iss1_valid(iss1_valid), .iss1_rj(iss1_rj), .iss1_rk(iss1_rk), .iss1_rd(iss1_rd),
      .iss1_use_rj(iss1_use_rj), .iss1_use_rk(iss1_use_rk), .iss1_we(iss1_we),
      .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb1_en(wb1_en), .wb1_addr(wb1_addr),
      .grant0(grant0), .grant1(grant1), .busy(busy),
      .stall_cycles(stall_cycles), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int d_of(input int r);
      return int'(wb0_en && wb0_addr == r) + int'(wb1_en && wb1_addr == r);
   endfunction

   function automatic bit rdy(input int r);
      return (r == 0) || (mc[r] - d_of(r) <= 0);
   endfunction

   // Spec rules: pending writers after this cycle's retirements, plus new writers, must fit in 3.
   task automatic model_grants();
      int n0, n1;
      n0  = mc[iss0_rd] - d_of(iss0_rd) + 1;
      n1  = mc[iss1_rd] - d_of(iss1_rd) + 1 + int'(iss0_we && iss0_rd == iss1_rd);
      mg0 = rstn && !flush && !stall_in && iss0_valid &&
            (!iss0_use_rj || rdy(iss0_rj)) && (!iss0_use_rk || rdy(iss0_rk)) &&
            (!(iss0_we && iss0_rd != 0) || n0 <= 3);
      mg1 = mg0 && iss1_valid &&
            (!iss1_use_rj || rdy(iss1_rj)) && (!iss1_use_rk || rdy(iss1_rk)) &&
            !(iss0_we && iss0_rd != 0 &&
              ((iss1_use_rj && iss1_rj == iss0_rd) || (iss1_use_rk && iss1_rk == iss0_rd))) &&
            (!(iss1_we && iss1_rd != 0) || n1 <= 3);
   endtask

   task automatic model_update();
      int v;
      if (!rstn) begin
         foreach (mc[r]) mc[r] = 0;
         mstall = 0;
         muf    = 0;
      end else begin
         if (iss0_valid && !mg0) mstall++;
         for (int r = 1; r < 32; r++) begin
            v = flush ? 0 : mc[r] + int'(mg0 && iss0_we && iss0_rd == r)
                              + int'(mg1 && iss1_we && iss1_rd == r) - d_of(r);
            if (v < 0) begin
               v   = 0;
               muf = 1;
            end
            mc[r] = v;
         end
      end
   endtask

   task automatic cyc();
      logic [31:0] mb;
      #1;
      model_grants();
      og0 = grant0;
      og1 = grant1;
      chk("grant0", grant0, mg0);
      chk("grant1", grant1, mg1);
      @(posedge clk);
      model_update();
      #1;
      mb = '0;
      for (int r = 1; r < 32; r++) mb[r] = (mc[r] != 0);
      chk("busy", busy, mb);
      chk("stall_cycles", stall_cycles, mstall);
      chk("underflow_err", underflow_err, muf);
      @(negedge clk);
   endtask

   task automatic idle();
      rstn = 1; flush = 0; stall_in = 0;
      iss0_valid = 0; iss0_rj = 0; iss0_rk = 0; iss0_rd = 0;
      iss0_use_rj = 0; iss0_use_rk = 0; iss0_we = 0;
      iss1_valid = 0; iss1_rj = 0; iss1_rk = 0; iss1_rd = 0;
      iss1_use_rj = 0; iss1_use_rk = 0; iss1_we = 0;
      wb0_en = 0; wb0_addr = 0; wb1_en = 0; wb1_addr = 0;
   endtask

   initial begin
      foreach (mc[r]) mc[r] = 0;
      mstall = 0; muf = 0;
      idle();
      rstn = 0;
      @(negedge clk);
      cyc(); cyc();
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_uf", underflow_err, 0);

      // r5 <- r1,r2 then a reader of r5 stalls
      idle(); iss0_valid = 1; iss0_rj = 1; iss0_rk = 2; iss0_rd = 5;
      iss0_use_rj = 1; iss0_use_rk = 1; iss0_we = 1;
      cyc();
      chk("s1_g0", og0, 1);
      chk("s1_busy5", busy[5], 1);
      idle(); iss0_valid = 1; iss0_rj = 5; iss0_use_rj = 1;
      cyc();
      chk("s1_blocked", og0, 0);
      cyc();
      chk("s1_stall2", stall_cycles, 2);

      // same-cycle writeback bypass
      wb0_en = 1; wb0_addr = 5;
      cyc();
      chk("s2_bypass", og0, 1);
      chk("s2_busy5", busy[5], 0);

      // intra-pair RAW, then paired writes to r7, then dual retire
      idle(); iss0_valid = 1; iss0_we = 1; iss0_rd = 7;
      iss1_valid = 1; iss1_use_rj = 1; iss1_rj = 7;
      cyc();
      chk("s3_raw_g0", og0, 1);
      chk("s3_raw_g1", og1, 0);
      idle(); iss0_valid = 1; iss0_we = 1; iss0_rd = 7;
      iss1_valid = 1; iss1_we = 1; iss1_rd = 7; wb0_en = 1; wb0_addr = 7;
      cyc();
      chk("s3_pair_g1", og1, 1);
      chk("s3_busy7", busy[7], 1);
      idle(); wb0_en = 1; wb0_addr = 7; wb1_en = 1; wb1_addr = 7;
      cyc();
      chk("s3_clear7", busy[7], 0);

      // in-order blocking and downstream stall
      idle(); iss0_valid = 1; iss0_we = 1; iss0_rd = 3;
      cyc();
      idle(); iss0_valid = 1; iss0_use_rj = 1; iss0_rj = 3;
      iss1_valid = 1; iss1_use_rj = 1; iss1_rj = 10; iss1_we = 1; iss1_rd = 11;
      cyc();
      chk("s4_inorder_g1", og1, 0);
      idle(); wb0_en = 1; wb0_addr = 3;
      cyc();
      idle(); stall_in = 1; iss0_valid = 1; iss0_use_rj = 1; iss0_rj = 1;
      iss1_valid = 1; iss1_use_rj = 1; iss1_rj = 2;
      cyc();
      chk("s4_stall_g0", og0, 0);
      chk("s4_stall_g1", og1, 0);

      // counter saturation on r9
      idle(); iss0_valid = 1; iss0_we = 1; iss0_rd = 9;
      repeat (3) cyc();
      cyc();
      chk("s5_sat", og0, 0);
      wb0_en = 1; wb0_addr = 9;
      cyc();
      chk("s5_sat_wb", og0, 1);
      wb0_en = 0;
      cyc();
      chk("s5_still_sat", og0, 0);

      // flush, post-flush underflow, mid-run reset
      idle(); iss0_valid = 1; iss0_we = 1; iss0_rd = 4;
      iss1_valid = 1; iss1_we = 1; iss1_rd = 4;
      cyc();
      idle(); iss0_valid = 1; iss0_we = 1; iss0_rd = 6;
      cyc();
      idle(); flush = 1; iss0_valid = 1; iss0_we = 1; iss0_rd = 12;
      cyc();
      chk("s6_flush_g0", og0, 0);
      chk("s6_flush_busy", busy, 0);
      idle(); wb0_en = 1; wb0_addr = 4;
      cyc();
      chk("s6_uf", underflow_err, 1);
      chk("s6_busy4", busy[4], 0);
      idle(); rstn = 0; iss0_valid = 1; iss0_we = 1; iss0_rd = 13;
      cyc();
      chk("s6_rst_g0", og0, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_stall", stall_cycles, 0);
      chk("s6_rst_uf", underflow_err, 0);

      // random traffic on a small register window to force frequent hazards
      for (int i = 0; i < 400; i++) begin
         rstn        = ($urandom_range(0, 63) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         stall_in    = ($urandom_range(0, 7) == 0);
         iss0_valid  = ($urandom_range(0, 3) != 0);
         iss0_rj     = 5'($urandom_range(0, 7));
         iss0_rk     = 5'($urandom_range(0, 7));
         iss0_rd     = 5'($urandom_range(0, 7));
         iss0_use_rj = 1'($urandom);
         iss0_use_rk = 1'($urandom);
         iss0_we     = 1'($urandom);
         iss1_valid  = 1'($urandom);
         iss1_rj     = 5'($urandom_range(0, 7));
         iss1_rk     = 5'($urandom_range(0, 7));
         iss1_rd     = 5'($urandom_range(0, 7));
         iss1_use_rj = 1'($urandom);
         iss1_use_rk = 1'($urandom);
         iss1_we     = 1'($urandom);
         wb0_en      = ($urandom_range(0, 2) == 0);
         wb0_addr    = 5'($urandom_range(0, 7));
         wb1_en      = ($urandom_range(0, 3) == 0);
         wb1_addr    = 5'($urandom_range(0, 7));
         cyc();
         if (og1 && !og0) chk("inorder", og1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
